// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI slave front end.
package spi_pkg;

    localparam int unsigned RX_WIDTH = 10;
    localparam int unsigned TX_WIDTH = 8;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t CHK_CMD   = 3'd1;
    localparam state_t WRITE     = 3'd2;
    localparam state_t READ_ADD  = 3'd3;
    localparam state_t READ_DATA = 3'd4;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_miso_shifter.sv
// Parallel-load, MSB-first serialiser driving MISO for one read-data byte.
module spi_miso_shifter
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH = TX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             miso,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] cnt;

    // MSB goes out on the cycle after load; the remaining bits follow, then MISO idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
            miso  <= 1'b0;
            busy  <= 1'b0;
        end else if (clr) begin
            shreg <= '0;
            cnt   <= '0;
            miso  <= 1'b0;
            busy  <= 1'b0;
        end else if (load) begin
            miso  <= data[WIDTH-1];
            shreg <= {data[WIDTH-2:0], 1'b0};
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            if (cnt == CNT_W'(WIDTH-1)) begin
                miso <= 1'b0;
                busy <= 1'b0;
            end else begin
                miso  <= shreg[WIDTH-1];
                shreg <= {shreg[WIDTH-2:0], 1'b0};
                cnt   <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave: deserialises 10-bit MOSI frames for the RAM and returns read data on MISO.
module spi_slave #(
    parameter int unsigned RX_WIDTH = spi_pkg::RX_WIDTH,
    parameter int unsigned TX_WIDTH = spi_pkg::TX_WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [RX_WIDTH-1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid
);

    import spi_pkg::*;

    localparam int unsigned CNT_W = $clog2(RX_WIDTH + 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    bit_cnt;
    logic [RX_WIDTH-1:0] rx_shift;
    logic                frame_done;
    logic                rd_addr_done;
    logic                tx_done;
    logic                tx_busy;
    logic                sample_c;
    logic                complete_c;
    logic                tx_load_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus per-edge sample/complete/load strobes.
    always_comb begin
        state_nxt  = state;
        sample_c   = 1'b0;
        complete_c = 1'b0;
        tx_load_c  = 1'b0;
        case (state)
            IDLE: begin
                if (!SS_n) begin
                    state_nxt = CHK_CMD;
                end
            end
            CHK_CMD: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end else begin
                    sample_c = 1'b1;
                    if (MOSI == OP_WR_ADDR[1]) begin
                        state_nxt = WRITE;
                    end else if (rd_addr_done) begin
                        state_nxt = READ_DATA;
                    end else begin
                        state_nxt = READ_ADD;
                    end
                end
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (SS_n) begin
                    state_nxt = IDLE;
                end else if (!frame_done) begin
                    sample_c   = 1'b1;
                    complete_c = (bit_cnt == CNT_W'(RX_WIDTH-1));
                end else if (state == READ_DATA) begin
                    tx_load_c = tx_valid && !tx_busy && !tx_done;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Frame capture; a partial frame never touches rx_data or the read-address flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_shift     <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            frame_done   <= 1'b0;
            rd_addr_done <= 1'b0;
            tx_done      <= 1'b0;
        end else begin
            rx_valid <= complete_c;
            if (state_nxt == IDLE) begin
                bit_cnt    <= '0;
                frame_done <= 1'b0;
                tx_done    <= 1'b0;
            end else if (sample_c) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (sample_c) begin
                rx_shift <= {rx_shift[RX_WIDTH-2:0], MOSI};
            end
            if (complete_c) begin
                rx_data    <= {rx_shift[RX_WIDTH-2:0], MOSI};
                frame_done <= 1'b1;
                if (state == READ_ADD) begin
                    rd_addr_done <= 1'b1;
                end else if (state == READ_DATA) begin
                    rd_addr_done <= 1'b0;
                end
            end
            if (tx_load_c) begin
                tx_done <= 1'b1;
            end
        end
    end

    spi_miso_shifter #(
        .WIDTH (TX_WIDTH)
    ) u_miso_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (SS_n),
        .load  (tx_load_c),
        .data  (tx_data),
        .miso  (MISO),
        .busy  (tx_busy)
    );

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed frame table, reset abort sequence and randomized frames vs a transaction model.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level model: last completed frame and the read-address-pending flag.
    bit         ref_flag;
    logic [9:0] ref_rx;

    typedef struct {
        logic [9:0] frame;
        int         nbits;
        bit         give_tx;
        logic [7:0] tx_byte;
        int         dly;
        int         exp_p;
        logic [9:0] exp_rx;
        bit         exp_ser;
    } vec_t;

    vec_t tbl [10];

    spi_slave dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Drives one frame of n bits; reports pulse count, pulse position, captured word and MISO activity.
    task automatic send_frame(input logic [9:0] f, input int n, output int p, output int pidx,
                              output logic [9:0] got, output bit mbad);
        p    = 0;
        pidx = -1;
        got  = '0;
        mbad = 1'b0;
        SS_n = 1'b0;
        @(negedge clk);
        if (MISO !== 1'b0) mbad = 1'b1;
        for (int i = 0; i < n; i++) begin
            MOSI = f[9-i];
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                p++;
                pidx = i;
                got  = rx_data;
            end
            if (MISO !== 1'b0) mbad = 1'b1;
        end
    endtask

    // Offers a byte on tx_valid, collects 10 MISO samples, then offers a second byte that must be ignored.
    task automatic serial_check(input string tag, input logic [7:0] b, input bit exp_ser);
        logic [9:0] s;
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
        for (int i = 0; i < 10; i++) begin
            s[9-i] = MISO;
            if (i < 9) @(negedge clk);
        end
        check({tag, "_miso_seq"}, 32'(s), exp_ser ? 32'({b, 2'b00}) : 32'd0);
        tx_valid = 1'b1;
        tx_data  = ~b;
        @(negedge clk);
        tx_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s[9-i] = MISO;
            @(negedge clk);
        end
        check({tag, "_miso_2nd_ignored"}, 32'(s), 32'd0);
    endtask

    task automatic commit(input logic [9:0] f, input int n);
        if (n == 10) begin
            ref_rx = f;
            if (f[9]) ref_flag = ref_flag ? 1'b0 : 1'b1;
        end
    endtask

    task automatic xact(input string tag, input logic [9:0] f, input int n, input bit give_tx,
                        input logic [7:0] b, input int dly, input int exp_p,
                        input logic [9:0] exp_rx, input bit exp_ser);
        int         p;
        int         pidx;
        logic [9:0] got;
        bit         mbad;
        send_frame(f, n, p, pidx, got, mbad);
        if (n == 10) begin
            @(negedge clk);
            check({tag, "_rv_one_cycle"}, 32'(rx_valid), 32'd0);
        end
        check({tag, "_pulses"}, 32'(p), 32'(exp_p));
        if (exp_p == 1) begin
            check({tag, "_pulse_pos"}, 32'(pidx), 32'(n-1));
            check({tag, "_rx_at_pulse"}, 32'(got), 32'(exp_rx));
        end
        check({tag, "_miso_quiet_rx"}, 32'(mbad), 32'd0);
        if (give_tx) begin
            repeat (dly) @(negedge clk);
            serial_check(tag, b, exp_ser);
        end
        commit(f, n);
        SS_n = 1'b1;
        MOSI = 1'($urandom);
        @(negedge clk);
        check({tag, "_end_miso"}, 32'(MISO), 32'd0);
        check({tag, "_end_rv"}, 32'(rx_valid), 32'd0);
        check({tag, "_end_rx"}, 32'(rx_data), 32'(exp_rx));
        @(negedge clk);
    endtask

    initial begin
        int         p;
        int         pidx;
        logic [9:0] got;
        bit         mbad;
        logic [2:0] s3;

        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        ref_flag = 1'b0;
        ref_rx   = 10'h000;

        tbl[0] = '{10'h0A5, 10, 1'b0, 8'h00, 0, 1, 10'h0A5, 1'b0};
        tbl[1] = '{10'h1F0, 10, 1'b0, 8'h00, 0, 1, 10'h1F0, 1'b0};
        tbl[2] = '{10'h203, 10, 1'b1, 8'hC3, 1, 1, 10'h203, 1'b0};
        tbl[3] = '{10'h300, 10, 1'b1, 8'hC3, 2, 1, 10'h300, 1'b1};
        tbl[4] = '{10'h0F0,  6, 1'b0, 8'h00, 0, 0, 10'h300, 1'b0};
        tbl[5] = '{10'h101, 10, 1'b0, 8'h00, 0, 1, 10'h101, 1'b0};
        tbl[6] = '{10'h055,  9, 1'b0, 8'h00, 0, 0, 10'h101, 1'b0};
        tbl[7] = '{10'h2AA, 10, 1'b0, 8'h00, 0, 1, 10'h2AA, 1'b0};
        tbl[8] = '{10'h211, 10, 1'b1, 8'h5A, 0, 1, 10'h211, 1'b1};
        tbl[9] = '{10'h100, 10, 1'b1, 8'hFF, 0, 1, 10'h100, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_miso", 32'(MISO), 32'd0);
        check("reset_rv", 32'(rx_valid), 32'd0);
        check("reset_rx", 32'(rx_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            xact($sformatf("v%0d", i), tbl[i].frame, tbl[i].nbits, tbl[i].give_tx, tbl[i].tx_byte,
                 tbl[i].dly, tbl[i].exp_p, tbl[i].exp_rx, tbl[i].exp_ser);
        end

        // Reset in the middle of a read-data byte, then a read frame must be treated as an address.
        xact("rst_pre", 10'h2C3, 10, 1'b0, 8'h00, 0, 1, 10'h2C3, 1'b0);
        send_frame(10'h3AA, 10, p, pidx, got, mbad);
        check("rst_rd_pulse", 32'(p), 32'd1);
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = 8'hE7;
        @(negedge clk);
        tx_valid = 1'b0;
        s3[2] = MISO;
        @(negedge clk);
        s3[1] = MISO;
        @(negedge clk);
        s3[0] = MISO;
        check("rst_first3_bits", 32'(s3), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_miso", 32'(MISO), 32'd0);
        check("rst_async_rv", 32'(rx_valid), 32'd0);
        check("rst_async_rx", 32'(rx_data), 32'd0);
        @(negedge clk);
        SS_n  = 1'b1;
        rst_n = 1'b1;
        ref_flag = 1'b0;
        ref_rx   = 10'h000;
        @(negedge clk);
        xact("rst_post", 10'h2C3, 10, 1'b1, 8'h99, 1, 1, 10'h2C3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [9:0] f;
            int         n;
            bit         gt;
            int         ep;
            logic [9:0] er;
            bit         es;
            f  = 10'($urandom);
            if (i % 3 == 1) f[9] = 1'b1;
            n  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
            gt = (n == 10) && ($urandom_range(0, 1) == 1);
            ep = (n == 10) ? 1 : 0;
            er = (n == 10) ? f : ref_rx;
            es = (n == 10) && f[9] && ref_flag;
            xact($sformatf("r%0d", i), f, n, gt, 8'($urandom), int'($urandom_range(0, 4)), ep, er, es);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- Serial front end for the single-port RAM.
- Deserialises 10-bit MOSI frames into parallel words and presents each to the RAM as rx_data/rx_valid.
- For read-data frames, accepts the RAM's 8-bit tx_data/tx_valid and serialises it MSB-first on MISO.
- Sits between the SPI pins and the RAM; drives the producer side of the RAM's din/rx_valid and consumes its dout/tx_valid.

Parameters:
- RX_WIDTH, 10, frame width: 2 opcode bits plus 8 address/data bits.
- TX_WIDTH, 8, read-data width returned on MISO.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- SS_n  input  1  slave select, active low; frames a transaction.
- MOSI  input  1  serial data from master, MSB first.
- MISO  output  1  serial read data to master, MSB first.
- rx_data  output  RX_WIDTH  received frame to RAM (RAM din).
- rx_valid  output  1  one-cycle strobe: rx_data complete.
- tx_data  input  TX_WIDTH  read data from RAM (RAM dout).
- tx_valid  input  1  tx_data valid strobe from RAM.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; MISO=0; rx_data=0; rx_valid=0.
  - Bit counter=0; rd_addr_done flag=0; TX shift register=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - SS_n=0 at an edge -> CHK_CMD. That edge is transaction cycle 0; no MOSI sampled.
  - Otherwise stay in IDLE.
- CHK_CMD (edge 1):
  - Sample MOSI as rx bit 9.
  - Bit 9 = 0 -> WRITE.
  - Bit 9 = 1 and rd_addr_done=0 -> READ_ADD.
  - Bit 9 = 1 and rd_addr_done=1 -> READ_DATA.
- Receive (WRITE, READ_ADD, READ_DATA), edges 2..10:
  - Sample MOSI into bits 8..0, MSB first.
  - After edge 10, rx_data holds all 10 sampled bits unmodified; the RAM decodes the opcode.
  - rx_valid=1 for exactly the one cycle following edge 10; otherwise 0.
  - rx_data holds its value until the next frame completes.
- Flag updates, at frame completion:
  - READ_ADD completion sets rd_addr_done=1.
  - READ_DATA completion clears it.
  - WRITE leaves it unchanged.
- After frame completion in WRITE or READ_ADD: stay in the state, ignore MOSI, until SS_n=1.
- READ_DATA, after rx_valid: wait for tx_valid=1. Wait is unbounded while SS_n=0.
  - On the edge sampling tx_valid=1: load tx_data into the shift register; MISO=tx_data[7] from the next cycle.
  - Each following edge shifts once; bits 7..0 appear on MISO on 8 consecutive cycles.
  - Then MISO=0. Further tx_valid pulses in the same transaction are ignored.
- MISO=0 in every state except during those 8 output cycles.
- SS_n=1 at any edge outside IDLE -> IDLE, with:
  - bit counter cleared and MISO=0;
  - a partial frame discarded: no rx_valid and no flag change;
  - rx_data retains its last completed value.
- SS_n=1 on the same edge as a frame's 10th bit: that bit is not sampled, so the frame is partial (no rx_valid).
- tx_valid outside READ_DATA is ignored.
- rst_n asserted mid-transaction aborts immediately to the reset values above.

Decomposition:
- Package spi_pkg holds:
  - state enum (IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA);
  - opcode constants OP_WR_ADDR=2'b00, OP_WR_DATA=2'b01, OP_RD_ADDR=2'b10, OP_RD_DATA=2'b11;
  - width constants RX_WIDTH and TX_WIDTH.
- One sub-module, spi_miso_shifter: parallel-load on tx_valid, 8-cycle MSB-first shift, busy output, clear on abort.

Test Plan:
- Write-address frame: SS_n low, MOSI bits 00_1010_0101, SS_n high -> rx_valid single pulse one cycle after edge 10, rx_data=10'h0A5, MISO=0 throughout, rd_addr_done=0.
- Write-data frame: MOSI 01_1111_0000 -> rx_data=10'h1F0, single rx_valid pulse; no state leak into the next frame (next frame starts in CHK_CMD).
- Read-address then read-data:
  - Frame 10_0000_0011 -> READ_ADD, rx_data=10'h203.
  - Frame 11_0000_0000 -> READ_DATA, rx_data=10'h300.
  - Model returns tx_valid with tx_data=8'hC3 -> MISO sequence 1,1,0,0,0,0,1,1 on 8 consecutive cycles, then 0; flag cleared.
- Abort: SS_n high after 6 bits of a write frame -> no rx_valid, rx_data unchanged; next full frame 01_0000_0001 -> rx_data=10'h101.
- Two consecutive read-address frames (no read-data between) -> second frame still in READ_DATA state (flag=1) -> rx_valid pulse, MISO serialises returned byte 8'h5A as 0,1,0,1,1,0,1,0.
- Reset during READ_DATA MISO shift (after 3 bits): rst_n low -> MISO=0, rx_valid=0, state IDLE, rd_addr_done=0 immediately; next read frame goes to READ_ADD.
